// File: rtl/alu_input_loader.sv
// Operand loader for the combinational ALU: synchronises switches and buttons, debounces
// each button, and captures the switch value into A, B or opcode on an accepted press.
module alu_input_loader #(
    parameter int NB_SW           = 8,
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NB_CNT          = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic [2:0]         i_btn,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_code,
    output logic [2:0]         o_loaded,
    output logic               o_valid
);

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    logic [NB_SW-1:0]  sw_meta;
    logic [NB_SW-1:0]  sw_s;
    logic [2:0]        btn_meta;
    logic [2:0]        btn_s;
    logic [2:0]        lvl;
    logic [2:0]        lvl_d;
    logic [2:0]        ld;
    logic [NB_CNT-1:0] cnt [3];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sw_meta  <= '0;
            sw_s     <= '0;
            btn_meta <= '0;
            btn_s    <= '0;
        end else begin
            sw_meta  <= i_sw;
            sw_s     <= sw_meta;
            btn_meta <= i_btn;
            btn_s    <= btn_meta;
        end
    end

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lvl   <= '0;
            lvl_d <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            lvl_d <= lvl;
            for (int unsigned i = 0; i < 3; i++) begin
                if (btn_s[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    lvl[i] <= btn_s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + NB_CNT'(1);
                end
            end
        end
    end

    always_comb begin
        ld = lvl & ~lvl_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data_a <= '0;
            o_data_b <= '0;
            o_code   <= '0;
            o_loaded <= '0;
            o_valid  <= 1'b0;
        end else begin
            if (ld[0]) begin
                o_data_a <= sw_s[NB_DATA-1:0];
            end
            if (ld[1]) begin
                o_data_b <= sw_s[NB_DATA-1:0];
            end
            if (ld[2]) begin
                o_code <= sw_s[NB_OP-1:0];
            end
            o_loaded <= o_loaded | ld;
            o_valid  <= (|ld) & (&(o_loaded | ld));
        end
    end

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader: press latency, glitch rejection, hold/bounce,
// simultaneous loads, reload after full, and reset during debounce.
module tb_alu_input_loader;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic [2:0] btn;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] code;
    logic [2:0] loaded;
    logic       valid;

    int errors = 0;
    int checks = 0;
    int pulses;

    alu_input_loader #(
        .NB_SW(8),
        .NB_DATA(8),
        .NB_OP(6),
        .DEBOUNCE_CYCLES(4),
        .NB_CNT(20)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_sw(sw),
        .i_btn(btn),
        .o_data_a(data_a),
        .o_data_b(data_b),
        .o_code(code),
        .o_loaded(loaded),
        .o_valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU for the three opcodes exercised here.
    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles, counting o_valid pulses seen after each edge.
    task automatic run_count(input int n, output int cnt_out);
        cnt_out = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) cnt_out++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        check("reset_data_a", 32'(data_a), 32'h00);
        check("reset_data_b", 32'(data_b), 32'h00);
        check("reset_code", 32'(code), 32'h00);
        check("reset_loaded", 32'(loaded), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sw    = 8'h00;
        btn   = 3'b000;
        cyc(1);
        do_reset();

        // Scenario 1: sequential loads of A, B and opcode
        sw = 8'h05; btn[0] = 1'b1;
        cyc(6);
        check("s1_a_before_load", 32'(data_a), 32'h00);
        cyc(1);
        check("s1_a", 32'(data_a), 32'h05);
        check("s1_loaded_a", 32'(loaded), 32'b001);
        check("s1_valid_after_a", 32'(valid), 32'h0);
        btn[0] = 1'b0;
        run_count(12, pulses);
        check("s1_release_a_pulses", 32'(pulses), 32'h0);

        sw = 8'h03; btn[1] = 1'b1;
        cyc(7);
        check("s1_b", 32'(data_b), 32'h03);
        check("s1_loaded_ab", 32'(loaded), 32'b011);
        check("s1_valid_after_b", 32'(valid), 32'h0);
        btn[1] = 1'b0;
        run_count(12, pulses);
        check("s1_release_b_pulses", 32'(pulses), 32'h0);

        sw = 8'h20; btn[2] = 1'b1;
        cyc(6);
        check("s1_valid_edge5", 32'(valid), 32'h0);
        check("s1_code_edge5", 32'(code), 32'h00);
        cyc(1);
        check("s1_valid_edge6", 32'(valid), 32'h1);
        check("s1_code", 32'(code), 32'h20);
        check("s1_loaded_all", 32'(loaded), 32'b111);
        check("s1_alu_add", 32'(alu(data_a, data_b, code)), 32'h08);
        cyc(1);
        check("s1_valid_edge7", 32'(valid), 32'h0);
        btn[2] = 1'b0;
        run_count(12, pulses);
        check("s1_release_c_pulses", 32'(pulses), 32'h0);

        // Scenario 5: reload opcode after full load
        sw = 8'h22; btn[2] = 1'b1;
        run_count(12, pulses);
        btn[2] = 1'b0;
        begin
            int more;
            run_count(12, more);
            pulses += more;
        end
        check("s5_pulses", 32'(pulses), 32'h1);
        check("s5_code", 32'(code), 32'h22);
        check("s5_a_kept", 32'(data_a), 32'h05);
        check("s5_b_kept", 32'(data_b), 32'h03);
        check("s5_alu_sub", 32'(alu(data_a, data_b, code)), 32'h02);

        // Scenario 3: hold btn1 for 50 cycles with a 2-cycle bounce at cycle 10
        sw = 8'h11;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            btn[1] = !(i == 10 || i == 11);
            if (i == 8) sw = 8'h44;
            @(negedge clk);
            if (valid) pulses++;
        end
        btn[1] = 1'b0;
        begin
            int more;
            run_count(15, more);
            pulses += more;
        end
        check("s3_single_load", 32'(pulses), 32'h1);
        check("s3_b_first_value", 32'(data_b), 32'h11);
        check("s3_a_kept", 32'(data_a), 32'h05);

        // Scenario 2: 3-cycle glitch on btn0 after reset
        do_reset();
        sw = 8'hFF; btn[0] = 1'b1;
        cyc(3);
        btn[0] = 1'b0;
        run_count(15, pulses);
        check("s2_no_valid", 32'(pulses), 32'h0);
        check("s2_loaded", 32'(loaded), 32'b000);
        check("s2_a", 32'(data_a), 32'h00);

        // Scenario 4: all three buttons on the same cycle
        sw = 8'hA7; btn = 3'b111;
        cyc(6);
        check("s4_loaded_edge5", 32'(loaded), 32'b000);
        cyc(1);
        check("s4_a", 32'(data_a), 32'hA7);
        check("s4_b", 32'(data_b), 32'hA7);
        check("s4_code", 32'(code), 32'h27);
        check("s4_loaded", 32'(loaded), 32'b111);
        check("s4_valid", 32'(valid), 32'h1);
        check("s4_alu_nor", 32'(alu(data_a, data_b, code)), 32'h58);
        btn = 3'b000;
        run_count(15, pulses);
        check("s4_no_extra_valid", 32'(pulses), 32'h0);

        // Scenario 6: reset while btn0 is mid-debounce, button kept held
        sw = 8'h3C; btn[0] = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        check("s6_reset_a", 32'(data_a), 32'h00);
        check("s6_reset_b", 32'(data_b), 32'h00);
        check("s6_reset_code", 32'(code), 32'h00);
        check("s6_reset_loaded", 32'(loaded), 32'b000);
        check("s6_reset_valid", 32'(valid), 32'h0);
        reset = 1'b0;
        cyc(6);
        check("s6_loaded_edge5", 32'(loaded), 32'b000);
        cyc(1);
        check("s6_loaded_edge6", 32'(loaded), 32'b001);
        check("s6_a", 32'(data_a), 32'h3C);
        check("s6_valid", 32'(valid), 32'h0);
        btn[0] = 1'b0;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
